// File: rtl/contador_captura_pkg.sv
// Shared encodings for the rco capture stage: counter modes, read-side states
// and the width of one captured {modo, Q} snapshot.
package contador_captura_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  localparam int Q_W_DEF = 4;
  localparam int CAP_W   = Q_W_DEF + 2;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_OUT  = 1'b1;

  // Snapshot width for an arbitrary counter width: mode bits sit above Q.
  function automatic int cap_w(input int q_w);
    return q_w + 2;
  endfunction

endpackage

// File: rtl/contador_captura_if.sv
// Counter-side inputs, read handshake and statistics of the capture stage.
// The stage itself uses the slave view; the driver/checker uses master.
interface contador_captura_if #(
  parameter int Q_W   = 4,
  parameter int CNT_W = 8
) ();

  logic             enable;
  logic [1:0]       modo;
  logic [Q_W-1:0]   Q;
  logic             rco;
  logic             rd_req;
  logic             rd_valid;
  logic [Q_W+1:0]   rd_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] ev_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output enable, modo, Q, rco, rd_req,
    input  rd_valid, rd_data, fifo_empty, fifo_full, ev_cnt, drop_cnt
  );

  modport slave (
    input  enable, modo, Q, rco, rd_req,
    output rd_valid, rd_data, fifo_empty, fifo_full, ev_cnt, drop_cnt
  );

endinterface

// File: rtl/contador_captura_fifo.sv
// Synchronous DEPTH x W FIFO with registered read; push/pop requests are
// qualified here and the accepted strobes are reported back as *_ack.
module contador_captura_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         push_ack,
  output logic         pop_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_INC  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic [W-1:0]     dout_reg;
  logic             full_reg, empty_reg;

  // A pop from a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ack  = pop & ~empty_reg;
  assign push_ack = push & (~full_reg | pop_ack);

  always_comb begin
    count_next = count_reg;
    if (push_ack && !pop_ack)
      count_next = count_reg + CNT_INC;
    else if (pop_ack && !push_ack)
      count_next = count_reg - CNT_INC;
  end

  // When full, wr_ptr == rd_ptr: the read below still sees the old word.
  always_ff @(posedge clk) begin
    if (push_ack)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (pop_ack) begin
        dout_reg   <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + PTR_INC;
      end
      if (push_ack)
        wr_ptr_reg <= wr_ptr_reg + PTR_INC;
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_FULL);
      empty_reg <= (count_next == '0);
    end
  end

  assign dout  = dout_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/contador_captura.sv
// Captures {modo, Q} on every enabled rising edge of rco into a small FIFO,
// drained through a one-cycle-latency read strobe, with saturating statistics.
module contador_captura
  import contador_captura_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int Q_W   = 4
) (
  input  logic clk,
  input  logic reset,
  contador_captura_if.slave bus
);

  localparam int CW = cap_w(Q_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  logic             rco_q_reg;
  logic             rco_event;
  logic             push_ack, pop_ack;
  logic [0:0]       rd_state_reg, rd_state_next;
  logic [CNT_W-1:0] ev_cnt_reg, drop_cnt_reg;

  // rco_q follows rco even while disabled, so an ignored edge stays spent
  // until rco falls.
  assign rco_event = bus.rco & ~rco_q_reg & bus.enable;

  contador_captura_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rco_event),
    .pop      (bus.rd_req),
    .din      ({bus.modo, bus.Q}),
    .dout     (bus.rd_data),
    .full     (bus.fifo_full),
    .empty    (bus.fifo_empty),
    .push_ack (push_ack),
    .pop_ack  (pop_ack)
  );

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (pop_ack)  rd_state_next = RD_OUT;
      RD_OUT:  if (!pop_ack) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rco_q_reg    <= 1'b0;
      rd_state_reg <= RD_IDLE;
      ev_cnt_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      rco_q_reg    <= bus.rco;
      rd_state_reg <= rd_state_next;
      if (rco_event && ev_cnt_reg != CNT_MAX)
        ev_cnt_reg <= ev_cnt_reg + CNT_INC;
      if (rco_event && !push_ack && drop_cnt_reg != CNT_MAX)
        drop_cnt_reg <= drop_cnt_reg + CNT_INC;
    end
  end

  assign bus.rd_valid = (rd_state_reg == RD_OUT);
  assign bus.ev_cnt   = ev_cnt_reg;
  assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_contador_captura.sv
// Directed bench for contador_captura: a queue-based model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_contador_captura;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int Q_W   = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  contador_captura_if #(.Q_W(Q_W), .CNT_W(CNT_W)) bus ();

  contador_captura #(.DEPTH(DEPTH), .CNT_W(CNT_W), .Q_W(Q_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of snapshots and two saturating tallies.
  logic [5:0] mq[$];
  int         m_ev, m_drop;
  bit         m_rco_p, m_valid, m_init;
  logic [5:0] m_data;

  initial m_init = 1'b0;

  always @(posedge clk) begin
    bit pop_now, evt_now;
    if (reset) begin
      mq.delete();
      m_ev = 0; m_drop = 0; m_rco_p = 0; m_valid = 0; m_data = '0;
      m_init = 1'b1;
    end else if (m_init) begin
      pop_now = bus.rd_req && (mq.size() > 0);
      evt_now = bus.rco && !m_rco_p && bus.enable;
      m_valid = pop_now;
      if (pop_now) m_data = mq.pop_front();
      if (evt_now) begin
        if (m_ev < 255) m_ev++;
        if (mq.size() < DEPTH) mq.push_back({bus.modo, bus.Q});
        else if (m_drop < 255) m_drop++;
      end
      m_rco_p = bus.rco;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      checks++;
      if (bus.rd_valid !== m_valid || bus.rd_data !== m_data ||
          bus.fifo_empty !== (mq.size() == 0) || bus.fifo_full !== (mq.size() == DEPTH) ||
          bus.ev_cnt !== CNT_W'(m_ev) || bus.drop_cnt !== CNT_W'(m_drop)) begin
        errors++;
        $display("FAIL model t=%0t: got valid=%b data=%h empty=%b full=%b ev=%0d drop=%0d, want valid=%b data=%h empty=%b full=%b ev=%0d drop=%0d",
                 $time, bus.rd_valid, bus.rd_data, bus.fifo_empty, bus.fifo_full, bus.ev_cnt, bus.drop_cnt,
                 m_valid, m_data, mq.size() == 0, mq.size() == DEPTH, m_ev, m_drop);
      end
      if (bus.rd_valid === 1'b1)
        $display("read t=%0t data=%h ev=%0d drop=%0d", $time, bus.rd_data, bus.ev_cnt, bus.drop_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic pulse_event(input logic [1:0] m, input logic [3:0] q);
    bus.modo = m; bus.Q = q; bus.rco = 1'b1;
    tick();
    bus.rco = 1'b0;
    tick();
  endtask

  task automatic read_one(input logic [5:0] exp, input string name);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    lit({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
    lit({name, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    logic [5:0] drain_exp [4];
    drain_exp[0] = 6'h12; drain_exp[1] = 6'h23; drain_exp[2] = 6'h34; drain_exp[3] = 6'h09;

    reset = 1'b1;
    bus.enable = 1'b0; bus.modo = 2'b00; bus.Q = '0; bus.rco = 1'b0; bus.rd_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    lit("rst_empty", 32'(bus.fifo_empty), 32'd1);
    lit("rst_full", 32'(bus.fifo_full), 32'd0);
    lit("rst_ev", 32'(bus.ev_cnt), 32'd0);
    lit("rst_drop", 32'(bus.drop_cnt), 32'd0);
    lit("rst_valid", 32'(bus.rd_valid), 32'd0);

    // Read while empty: no pulse.
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    lit("empty_read_valid", 32'(bus.rd_valid), 32'd0);
    tick();

    // Up-count 0..15, rco only at 15.
    bus.enable = 1'b1; bus.modo = 2'b00;
    for (int q = 0; q < 16; q++) begin
      bus.Q = 4'(q); bus.rco = (q == 15);
      tick();
    end
    bus.Q = '0; bus.rco = 1'b0;
    tick();
    lit("cap_ev", 32'(bus.ev_cnt), 32'd1);
    read_one(6'h0F, "cap_read");
    tick();
    lit("cap_valid_drop", 32'(bus.rd_valid), 32'd0);
    lit("cap_data_hold", 32'(bus.rd_data), 32'h0F);

    // rco held for 5 cycles in load mode: one event.
    bus.modo = 2'b11; bus.Q = 4'hF; bus.rco = 1'b1;
    repeat (5) tick();
    bus.rco = 1'b0;
    tick();
    lit("held_ev", 32'(bus.ev_cnt), 32'd2);

    // Edge while disabled, then enable returns with rco still high: ignored.
    bus.enable = 1'b0; bus.rco = 1'b1;
    tick();
    bus.enable = 1'b1;
    tick(); tick();
    bus.rco = 1'b0;
    tick();
    lit("disabled_ev", 32'(bus.ev_cnt), 32'd2);
    read_one(6'h3F, "held_read");
    tick();

    // Six events, no reads: four kept, two dropped.
    for (int k = 0; k < 6; k++) pulse_event(2'(k), 4'(k + 1));
    lit("ovf_full", 32'(bus.fifo_full), 32'd1);
    lit("ovf_ev", 32'(bus.ev_cnt), 32'd8);
    lit("ovf_drop", 32'(bus.drop_cnt), 32'd2);

    // Push and pop together while full.
    bus.modo = 2'b00; bus.Q = 4'h9; bus.rco = 1'b1; bus.rd_req = 1'b1;
    tick();
    bus.rco = 1'b0; bus.rd_req = 1'b0;
    lit("pp_valid", 32'(bus.rd_valid), 32'd1);
    lit("pp_data", 32'(bus.rd_data), 32'h01);
    lit("pp_drop", 32'(bus.drop_cnt), 32'd2);
    lit("pp_full", 32'(bus.fifo_full), 32'd1);
    lit("pp_ev", 32'(bus.ev_cnt), 32'd9);

    // Back-to-back drain.
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      lit("drain_valid", 32'(bus.rd_valid), 32'd1);
      lit("drain_data", 32'(bus.rd_data), 32'(drain_exp[i]));
    end
    bus.rd_req = 1'b0;
    tick();
    lit("drain_empty", 32'(bus.fifo_empty), 32'd1);
    lit("drain_valid_end", 32'(bus.rd_valid), 32'd0);

    // Reset with entries queued and a read in flight.
    pulse_event(2'b01, 4'h5);
    pulse_event(2'b01, 4'h6);
    pulse_event(2'b01, 4'h7);
    bus.rd_req = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.rd_req = 1'b0;
    lit("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    lit("mid_rst_empty", 32'(bus.fifo_empty), 32'd1);
    lit("mid_rst_ev", 32'(bus.ev_cnt), 32'd0);
    lit("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
    lit("mid_rst_data", 32'(bus.rd_data), 32'd0);
    tick();
    lit("post_rst_valid", 32'(bus.rd_valid), 32'd0);
    pulse_event(2'b10, 4'hA);
    read_one(6'h2A, "post_rst_read");
    tick();
    lit("post_rst_ev", 32'(bus.ev_cnt), 32'd1);

    // Saturation of both counters.
    for (int k = 0; k < 260; k++) pulse_event(2'b00, 4'(k));
    lit("sat_ev", 32'(bus.ev_cnt), 32'hFF);
    lit("sat_drop", 32'(bus.drop_cnt), 32'hFF);
    lit("sat_full", 32'(bus.fifo_full), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
